bus_demux_gather: RTL and testbench



---
 rtl/bus_demux_gather.sv | 74 +++++++
 tb/tb_bus_demux_gather.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_demux_gather.sv
// Word-to-bus gatherer: packs a stream of DAT_WIDTH words into one TOTAL_DAT frame.
// Gather stage (p0) feeds a registered output stage (p1); short frames end on din_last.
module bus_demux_gather #(
   parameter int DAT_WIDTH = 16,
   parameter int SEL_WIDTH = 3,
   parameter int TOTAL_DAT = DAT_WIDTH << SEL_WIDTH,
   parameter int NUM_WORDS = 1 << SEL_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DAT_WIDTH-1:0] din,
   input  logic                 din_valid,
   input  logic                 din_last,
   output logic                 din_ready,
   output logic [TOTAL_DAT-1:0] dout,
   output logic [NUM_WORDS-1:0] dout_mask,
   output logic                 dout_valid,
   input  logic                 dout_ready
);

   logic [TOTAL_DAT-1:0] gbuf_p0;
   logic [NUM_WORDS-1:0] gmask_p0;
   logic [SEL_WIDTH-1:0] gidx_p0;
   logic                 vld_p0;

   logic accept;
   logic xfer;
   logic last_word;

   assign din_ready = !vld_p0;
   assign accept    = din_valid & din_ready;
   assign xfer      = vld_p0 & (!dout_valid | dout_ready);
   assign last_word = din_last | (gidx_p0 == SEL_WIDTH'(NUM_WORDS - 1));

   // Stage p0: gather lanes until the frame is full or din_last closes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gbuf_p0  <= '0;
         gmask_p0 <= '0;
         gidx_p0  <= '0;
         vld_p0   <= 1'b0;
      end else if (xfer) begin
         // cleared on handoff so unfilled lanes of the next short frame read 0
         gbuf_p0  <= '0;
         gmask_p0 <= '0;
         vld_p0   <= 1'b0;
      end else if (accept) begin
         gbuf_p0[gidx_p0*DAT_WIDTH +: DAT_WIDTH] <= din;
         gmask_p0[gidx_p0]                       <= 1'b1;
         if (last_word) begin
            vld_p0  <= 1'b1;
            gidx_p0 <= '0;
         end else begin
            gidx_p0 <= gidx_p0 + 1'b1;
         end
      end
   end

   // Stage p1: output register, refilled in the same cycle it is released
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout       <= '0;
         dout_mask  <= '0;
         dout_valid <= 1'b0;
      end else if (xfer) begin
         dout       <= gbuf_p0;
         dout_mask  <= gmask_p0;
         dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bus_demux_gather.sv
// Scoreboard bench for bus_demux_gather: directed frames, backpressure, reset, random gaps.
module tb_bus_demux_gather;
   localparam int DW = 16;
   localparam int SW = 3;
   localparam int NW = 8;
   localparam int TD = 128;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] din;
   logic          din_valid;
   logic          din_last;
   logic          din_ready;
   logic [TD-1:0] dout;
   logic [NW-1:0] dout_mask;
   logic          dout_valid;
   logic          dout_ready;

   typedef struct {
      logic [TD-1:0] d;
      logic [NW-1:0] m;
   } frame_t;

   frame_t sb_q[$];
   int     checks   = 0;
   int     failures = 0;
   bit     rand_ready = 1'b0;

   bus_demux_gather #(.DAT_WIDTH(DW), .SEL_WIDTH(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .din_valid (din_valid),
      .din_last  (din_last),
      .din_ready (din_ready),
      .dout      (dout),
      .dout_mask (dout_mask),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [TD-1:0] act, input logic [TD-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [TD-1:0] d, input logic [NW-1:0] m);
      frame_t f;
      f.d = d;
      f.m = m;
      sb_q.push_back(f);
   endtask

   // Called at posedge+1; returns at posedge+1 after the edge that accepted the word.
   task automatic send_word(input logic [DW-1:0] w, input bit last, input int gap);
      bit ok;
      int t;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      din       = w;
      din_valid = 1'b1;
      din_last  = last;
      t = 0;
      ok = 1'b0;
      while (!ok && t < 2000) begin
         @(negedge clk);
         ok = din_ready;
         @(posedge clk);
         #1;
         t++;
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: got din_ready=0 expected accept within 2000 cycles");
      end
      din_valid = 1'b0;
      din_last  = 1'b0;
   endtask

   task automatic send_seq(input logic [DW-1:0] base, input int n, input bit last_on_end);
      for (int i = 0; i < n; i++)
         send_word(base + DW'(i), last_on_end && (i == n - 1), 0);
   endtask

   // Monitor: every output handshake pops one expected frame
   always @(negedge clk) begin
      if (rst_n && dout_valid && dout_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_extra: got frame %h mask %h expected no frame", dout, dout_mask);
         end else begin
            frame_t f;
            f = sb_q.pop_front();
            chk("sb_dout", dout, f.d);
            chk("sb_mask", TD'(dout_mask), TD'(f.m));
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         dout_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      logic [DW-1:0] w[NW];
      logic [TD-1:0] ed;
      logic [NW-1:0] em;
      int            n;
      int            t;
      bit            lst;

      rst_n = 1'b0;
      din = '0;
      din_valid = 1'b0;
      din_last = 1'b0;
      dout_ready = 1'b1;
      #1;
      chk("rst_dout_valid", TD'(dout_valid), TD'(0));
      chk("rst_dout_mask", TD'(dout_mask), TD'(0));
      chk("rst_dout", dout, TD'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_din_ready", TD'(din_ready), TD'(1));

      // Full frame with free output: latency and single-cycle din_ready bubble
      push_exp(128'h1007_1006_1005_1004_1003_1002_1001_1000, 8'hFF);
      send_seq(16'h1000, 8, 1'b0);
      chk("full_ready_low", TD'(din_ready), TD'(0));
      chk("full_not_yet_valid", TD'(dout_valid), TD'(0));
      @(posedge clk);
      #1;
      chk("full_valid_T1", TD'(dout_valid), TD'(1));
      chk("full_ready_back", TD'(din_ready), TD'(1));
      @(posedge clk);
      #1;
      chk("full_valid_pulse", TD'(dout_valid), TD'(0));

      // Short frame then single-word frame restarting at lane 0
      push_exp({80'h0, 16'h00A2, 16'h00A1, 16'h00A0}, 8'h07);
      send_seq(16'h00A0, 3, 1'b1);
      push_exp({112'h0, 16'hBEEF}, 8'h01);
      send_word(16'hBEEF, 1'b1, 0);
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: frame 1 held on dout, frame 2 parked in gather
      dout_ready = 1'b0;
      push_exp(128'h2007_2006_2005_2004_2003_2002_2001_2000, 8'hFF);
      push_exp(128'h3007_3006_3005_3004_3003_3002_3001_3000, 8'hFF);
      push_exp(128'h4007_4006_4005_4004_4003_4002_4001_4000, 8'hFF);
      send_seq(16'h2000, 8, 1'b0);
      send_seq(16'h3000, 8, 1'b1);
      din = 16'h4000;
      din_valid = 1'b1;
      din_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_din_ready", TD'(din_ready), TD'(0));
         chk("bp_dout_hold", dout, 128'h2007_2006_2005_2004_2003_2002_2001_2000);
         chk("bp_dout_valid", TD'(dout_valid), TD'(1));
      end
      @(posedge clk);
      #1;
      dout_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_frame2_valid", TD'(dout_valid), TD'(1));
      chk("bp_frame2_dout", dout, 128'h3007_3006_3005_3004_3003_3002_3001_3000);
      chk("bp_ready_resume", TD'(din_ready), TD'(1));
      send_seq(16'h4000, 8, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      // Reset mid-frame with a pending output frame: both discarded
      dout_ready = 1'b0;
      send_seq(16'h6000, 8, 1'b0);
      send_seq(16'h5000, 5, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", TD'(dout_valid), TD'(0));
      chk("mid_rst_mask", TD'(dout_mask), TD'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      dout_ready = 1'b1;
      push_exp(128'h7007_7006_7005_7004_7003_7002_7001_7000, 8'hFF);
      send_seq(16'h7000, 8, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      // Random lengths, gaps and output stalls
      rand_ready = 1'b1;
      for (int f = 0; f < 1000; f++) begin
         n = $urandom_range(1, 8);
         ed = '0;
         for (int i = 0; i < n; i++) begin
            w[i] = DW'($urandom);
            ed[i*DW +: DW] = w[i];
         end
         em = NW'((1 << n) - 1);
         push_exp(ed, em);
         for (int i = 0; i < n; i++) begin
            lst = (i == n - 1) && ((n < NW) || ($urandom_range(0, 1) == 1));
            send_word(w[i], lst, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
         end
      end

      t = 0;
      while (sb_q.size() != 0 && t < 1000) begin
         @(posedge clk);
         t++;
      end
      rand_ready = 1'b0;
      chk("sb_drained", TD'(sb_q.size()), TD'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
